// File: rtl/pol_pkg.sv
// pol_pkg: shared defaults, lane type and controller state codes.
// Build option POL_SIGNED_EN selects signed lane compare in pol_max_acc.
package pol_pkg;

    localparam int POL_ACT_WIDTH  = 8;
    localparam int POL_LANES      = 64;
    localparam int POL_IDX_WIDTH  = 10;
    localparam int POL_K_WIDTH    = 5;
    localparam int POL_MAX_OUTSTD = 8;

    typedef logic [POL_ACT_WIDTH-1:0] lane_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/pol_max_acc.sv
// pol_max_acc: lane-wise max-accumulate over the returns of one point.
// POL_SIGNED_EN defined: signed lanes; otherwise unsigned lanes.
module pol_max_acc
    import pol_pkg::*;
#(
    parameter int LANES = POL_LANES,
    parameter int LW    = POL_ACT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                first,
    input  logic [LANES*LW-1:0] fm,
    output logic [LANES*LW-1:0] res
);

    logic [LANES*LW-1:0] acc;

    function automatic logic lane_gt(
        input logic [LW-1:0] a,
        input logic [LW-1:0] b
    );
`ifdef POL_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Running max; the first return of a point bypasses the accumulator.
    always_comb begin
        res = fm;
        for (int j = 0; j < LANES; j++) begin
            if (!first && lane_gt(acc[j*LW +: LW], fm[j*LW +: LW]))
                res[j*LW +: LW] = acc[j*LW +: LW];
        end
    end

    // Accumulator captures the merged vector on every accepted return.
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= res;
    end

endmodule

// File: rtl/pol_core.sv
// pol_core: one pooling core; issues neighbour addresses, max-reduces
// K returns per point, emits pooled vectors. Option: POL_SIGNED_EN.
module pol_core
    import pol_pkg::*;
#(
    parameter int POOL_COMP_CORE = POL_LANES,
    parameter int ACT_WIDTH      = POL_ACT_WIDTH,
    parameter int IDX_WIDTH      = POL_IDX_WIDTH,
    parameter int K_WIDTH        = POL_K_WIDTH,
    parameter int MAX_OUTSTD     = POL_MAX_OUTSTD
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                CCUPOL_Start,
    input  logic [K_WIDTH-1:0]                  CCUPOL_K,
    input  logic [IDX_WIDTH-1:0]                CCUPOL_NumPnt,
    output logic                                POLCCU_Done,
    input  logic [IDX_WIDTH-1:0]                GLBPOL_Idx,
    input  logic                                GLBPOL_IdxVld,
    output logic                                POLGLB_IdxRdy,
    output logic [IDX_WIDTH-1:0]                POLMIF_Addr,
    output logic                                POLMIF_AddrVld,
    input  logic                                MIFPOL_Rdy,
    input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] MIFPOL_Fm,
    input  logic                                MIFPOL_FmVld,
    output logic                                MIFPOL_FmRdy,
    output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLGLB_Fm,
    output logic                                POLGLB_FmVld,
    input  logic                                GLBPOL_FmRdy
);

    localparam int FW = ACT_WIDTH * POOL_COMP_CORE;
    localparam int CW = K_WIDTH + IDX_WIDTH;
    localparam int OW = $clog2(MAX_OUTSTD + 1);

    logic [1:0]           state;
    logic [K_WIDTH-1:0]   k_reg;
    logic [K_WIDTH-1:0]   kcnt;
    logic [IDX_WIDTH-1:0] npnt_reg;
    logic [IDX_WIDTH-1:0] pcnt;
    logic [CW-1:0]        issued;
    logic [CW-1:0]        total;
    logic [OW-1:0]        outstd;
    logic                 run;
    logic                 launch;
    logic                 cfg_zero;
    logic                 idx_acc;
    logic                 fm_acc;
    logic                 out_acc;
    logic                 last_k;
    logic                 last_p;
    logic [FW-1:0]        res;

    assign run      = state == RUN;
    assign launch   = state == IDLE && CCUPOL_Start;
    assign cfg_zero = CCUPOL_K == '0 || CCUPOL_NumPnt == '0;
    assign total    = CW'(k_reg) * CW'(npnt_reg);
    assign last_k   = kcnt == k_reg - K_WIDTH'(1);
    assign last_p   = pcnt == npnt_reg - IDX_WIDTH'(1);

    assign POLGLB_IdxRdy = run && issued < total
                        && outstd < OW'(MAX_OUTSTD)
                        && (!POLMIF_AddrVld || MIFPOL_Rdy);
    assign MIFPOL_FmRdy  = run
                        && !(last_k && POLGLB_FmVld && !GLBPOL_FmRdy);
    assign POLCCU_Done   = state == DONE;

    assign idx_acc = GLBPOL_IdxVld && POLGLB_IdxRdy;
    assign fm_acc  = MIFPOL_FmVld && MIFPOL_FmRdy;
    assign out_acc = POLGLB_FmVld && GLBPOL_FmRdy;

    // Layer sequencing; config is captured with the start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k_reg    <= '0;
            npnt_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CCUPOL_Start) begin
                        k_reg    <= CCUPOL_K;
                        npnt_reg <= CCUPOL_NumPnt;
                        state    <= cfg_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (out_acc && last_p)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Issue count, in-flight credits and per-point counters.
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            issued <= '0;
            outstd <= '0;
            kcnt   <= '0;
            pcnt   <= '0;
        end else begin
            if (idx_acc)
                issued <= issued + CW'(1);
            if (idx_acc && !fm_acc)
                outstd <= outstd + OW'(1);
            else if (!idx_acc && fm_acc)
                outstd <= outstd - OW'(1);
            if (fm_acc)
                kcnt <= last_k ? '0 : kcnt + K_WIDTH'(1);
            if (out_acc)
                pcnt <= pcnt + IDX_WIDTH'(1);
        end
    end

    // Address register slice toward the memory interface.
    always_ff @(posedge clk) begin
        if (rst) begin
            POLMIF_Addr    <= '0;
            POLMIF_AddrVld <= 1'b0;
        end else if (idx_acc) begin
            POLMIF_Addr    <= GLBPOL_Idx;
            POLMIF_AddrVld <= 1'b1;
        end else if (MIFPOL_Rdy) begin
            POLMIF_AddrVld <= 1'b0;
        end
    end

    pol_max_acc #(
        .LANES (POOL_COMP_CORE),
        .LW    (ACT_WIDTH)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .en    (fm_acc),
        .first (kcnt == '0),
        .fm    (MIFPOL_Fm),
        .res   (res)
    );

    // Pooled output: a completing return loads, even while draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            POLGLB_Fm    <= '0;
            POLGLB_FmVld <= 1'b0;
        end else if (fm_acc && last_k) begin
            POLGLB_Fm    <= res;
            POLGLB_FmVld <= 1'b1;
        end else if (GLBPOL_FmRdy) begin
            POLGLB_FmVld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pol_core.sv
// tb_pol_core: randomized GLB/MIF traffic against a pooling model.
// Model follows POL_SIGNED_EN for lane ordering.
`timescale 1ns/1ps
module tb_pol_core;

    localparam int LN = 64;
    localparam int AW = 8;
    localparam int IW = 10;
    localparam int KW = 5;
    localparam int FW = LN * AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          CCUPOL_Start;
    logic [KW-1:0] CCUPOL_K;
    logic [IW-1:0] CCUPOL_NumPnt;
    logic          POLCCU_Done;
    logic [IW-1:0] GLBPOL_Idx;
    logic          GLBPOL_IdxVld;
    logic          POLGLB_IdxRdy;
    logic [IW-1:0] POLMIF_Addr;
    logic          POLMIF_AddrVld;
    logic          MIFPOL_Rdy;
    logic [FW-1:0] MIFPOL_Fm;
    logic          MIFPOL_FmVld;
    logic          MIFPOL_FmRdy;
    logic [FW-1:0] POLGLB_Fm;
    logic          POLGLB_FmVld;
    logic          GLBPOL_FmRdy;

    pol_core dut (
        .clk            (clk),
        .rst            (rst),
        .CCUPOL_Start   (CCUPOL_Start),
        .CCUPOL_K       (CCUPOL_K),
        .CCUPOL_NumPnt  (CCUPOL_NumPnt),
        .POLCCU_Done    (POLCCU_Done),
        .GLBPOL_Idx     (GLBPOL_Idx),
        .GLBPOL_IdxVld  (GLBPOL_IdxVld),
        .POLGLB_IdxRdy  (POLGLB_IdxRdy),
        .POLMIF_Addr    (POLMIF_Addr),
        .POLMIF_AddrVld (POLMIF_AddrVld),
        .MIFPOL_Rdy     (MIFPOL_Rdy),
        .MIFPOL_Fm      (MIFPOL_Fm),
        .MIFPOL_FmVld   (MIFPOL_FmVld),
        .MIFPOL_FmRdy   (MIFPOL_FmRdy),
        .POLGLB_Fm      (POLGLB_Fm),
        .POLGLB_FmVld   (POLGLB_FmVld),
        .GLBPOL_FmRdy   (GLBPOL_FmRdy)
    );

    always #5 clk = ~clk;

    logic [FW-1:0] mem [1024];
    int            total_c = 0;
    int            bad = 0;
    int            K, N, TOT;
    int            idx_list[$];
    int            mq[$];
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] got_q[$];
    int            n_ih, n_ah, n_fh, n_oh, n_done;
    int            ncyc = 0;
    int            start_cyc, last_out, done_cyc;
    int            src_ptr, ret_budget, sink_mode;
    bit            src_full, rdy_full, src_en, run_flag;
    bit            prev_ih, prev_av, prev_ah, prev_ov, prev_oh;
    logic [IW-1:0] prev_idx, prev_addr;
    logic [FW-1:0] prev_fm;
    logic [AW-1:0] lane_exp;

    task automatic chk(input string tag,
                       input logic [FW+7:0] obs,
                       input logic [FW+7:0] exp);
        total_c++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] vmax(input logic [FW-1:0] a,
                                           input logic [FW-1:0] b);
        logic [FW-1:0] r;
        logic [AW-1:0] x, y;
        for (int j = 0; j < LN; j++) begin
            x = a[j*AW +: AW];
            y = b[j*AW +: AW];
`ifdef POL_SIGNED_EN
            r[j*AW +: AW] = ($signed(x) > $signed(y)) ? x : y;
`else
            r[j*AW +: AW] = (x > y) ? x : y;
`endif
        end
        return r;
    endfunction

    // One clock: check at negedge, then update bench drivers after posedge.
    task automatic cyc();
        bit ih, ah, fh, oh;
        int kpos, ea;
        @(negedge clk);
        ncyc++;
        ih = GLBPOL_IdxVld && POLGLB_IdxRdy;
        ah = POLMIF_AddrVld && MIFPOL_Rdy;
        fh = MIFPOL_FmVld && MIFPOL_FmRdy;
        oh = POLGLB_FmVld && GLBPOL_FmRdy;
        kpos = (K == 0) ? 0 : n_fh % K;
        chk("idx_rdy", POLGLB_IdxRdy,
            run_flag && n_ih < TOT && n_ih - n_fh < 8
            && (!POLMIF_AddrVld || MIFPOL_Rdy));
        chk("fm_rdy", MIFPOL_FmRdy,
            run_flag && !(kpos == K - 1 && POLGLB_FmVld && !GLBPOL_FmRdy));
        if (prev_ih)
            chk("addr_slice", {POLMIF_AddrVld, POLMIF_Addr}, {1'b1, prev_idx});
        if (prev_av && !prev_ah)
            chk("addr_hold", {POLMIF_AddrVld, POLMIF_Addr}, {1'b1, prev_addr});
        if (prev_ov && !prev_oh)
            chk("out_hold", {POLGLB_FmVld, POLGLB_Fm}, {1'b1, prev_fm});
        if (ih)
            n_ih++;
        if (ah) begin
            ea = (n_ah < TOT) ? idx_list[n_ah] : -1;
            chk("addr_order", int'(POLMIF_Addr), ea);
            mq.push_back(int'(POLMIF_Addr));
            n_ah++;
        end
        if (fh)
            n_fh++;
        if (oh) begin
            chk("pool", POLGLB_Fm, (n_oh < N) ? exp_q[n_oh] : '1);
            got_q.push_back(POLGLB_Fm);
            n_oh++;
            if (n_oh == N)
                last_out = ncyc;
        end
        if (POLCCU_Done) begin
            n_done++;
            done_cyc = ncyc;
        end
        prev_ih   = ih;
        prev_idx  = GLBPOL_Idx;
        prev_av   = POLMIF_AddrVld;
        prev_ah   = ah;
        prev_addr = POLMIF_Addr;
        prev_ov   = POLGLB_FmVld;
        prev_oh   = oh;
        prev_fm   = POLGLB_Fm;
        @(posedge clk);
        #1;
        if (oh && n_oh == N)
            run_flag = 0;
        if (ih)
            src_ptr++;
        if (!GLBPOL_IdxVld || ih) begin
            if (src_en && src_ptr < TOT
                && (src_full || $urandom_range(0, 3) != 0)) begin
                GLBPOL_IdxVld = 1'b1;
                GLBPOL_Idx    = IW'(idx_list[src_ptr]);
            end else begin
                GLBPOL_IdxVld = 1'b0;
            end
        end
        MIFPOL_Rdy = rdy_full || $urandom_range(0, 3) != 0;
        if (fh)
            void'(mq.pop_front());
        if (!MIFPOL_FmVld || fh) begin
            if (ret_budget != 0 && mq.size() > 0
                && (ret_budget > 0 || $urandom_range(0, 3) != 0)) begin
                MIFPOL_FmVld = 1'b1;
                MIFPOL_Fm    = mem[mq[0]];
                if (ret_budget > 0)
                    ret_budget--;
            end else begin
                MIFPOL_FmVld = 1'b0;
            end
        end
        GLBPOL_FmRdy = (sink_mode == 1)
                    || (sink_mode == 0 && $urandom_range(0, 2) != 0);
    endtask

    task automatic start_layer(input int k, input int n, input bit keep);
        logic [FW-1:0] v;
        K   = k;
        N   = n;
        TOT = k * n;
        if (!keep) begin
            idx_list.delete();
            for (int i = 0; i < TOT; i++)
                idx_list.push_back(int'($urandom_range(0, 1023)));
        end
        exp_q.delete();
        got_q.delete();
        mq.delete();
        if (TOT > 0) begin
            for (int p = 0; p < N; p++) begin
                v = mem[idx_list[p*K]];
                for (int i = 1; i < K; i++)
                    v = vmax(v, mem[idx_list[p*K+i]]);
                exp_q.push_back(v);
            end
        end
        n_ih = 0; n_ah = 0; n_fh = 0; n_oh = 0; n_done = 0;
        src_ptr = 0; last_out = -1; done_cyc = -1;
        prev_ih = 0; prev_av = 0; prev_ov = 0;
        CCUPOL_Start  = 1'b1;
        CCUPOL_K      = KW'(k);
        CCUPOL_NumPnt = IW'(n);
        cyc();
        CCUPOL_Start = 1'b0;
        start_cyc = ncyc;
        run_flag  = TOT != 0;
    endtask

    task automatic run_layer(input int k, input int n, input bit keep,
                             input bit sf, input bit rf, input int hold);
        src_full   = sf;
        rdy_full   = rf;
        src_en     = 1;
        ret_budget = -1;
        sink_mode  = (hold > 0) ? 2 : int'($urandom_range(0, 1));
        start_layer(k, n, keep);
        for (int c = 0; c < 4000 && n_done == 0; c++) begin
            if (hold > 0 && ncyc == start_cyc + hold) begin
                if (K == 2) begin
                    chk("stall_fh", n_fh, 3);
                    chk("stall_vld", POLGLB_FmVld, 1'b1);
                end
                sink_mode = 1;
            end
            cyc();
        end
        chk("done_seen", n_done, 1);
        repeat (3) cyc();
        chk("done_once", n_done, 1);
        chk("done_cyc", done_cyc, (TOT == 0) ? start_cyc + 1 : last_out + 1);
        chk("n_points", n_oh, (TOT == 0) ? 0 : N);
        chk("n_addr", n_ah, TOT);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst           = 1'b1;
        CCUPOL_Start  = 1'b0;
        GLBPOL_IdxVld = 1'b0;
        MIFPOL_FmVld  = 1'b0;
        MIFPOL_Rdy    = 1'b0;
        GLBPOL_FmRdy  = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_ctl"},
            {POLCCU_Done, POLGLB_IdxRdy, POLMIF_AddrVld,
             MIFPOL_FmRdy, POLGLB_FmVld, POLMIF_Addr}, '0);
        chk({tag, "_fm"}, POLGLB_Fm, '0);
        rst = 1'b0;
        run_flag = 0; src_en = 0; ret_budget = 0;
        prev_ih = 0; prev_av = 0; prev_ov = 0;
        mq.delete();
    endtask

    initial begin
        for (int a = 0; a < 1024; a++)
            for (int w = 0; w < FW / 32; w++)
                mem[a][w*32 +: 32] = $urandom;
        rst = 1'b1; CCUPOL_Start = 0; CCUPOL_K = '0; CCUPOL_NumPnt = '0;
        GLBPOL_Idx = '0; GLBPOL_IdxVld = 0; MIFPOL_Rdy = 0;
        MIFPOL_Fm = '0; MIFPOL_FmVld = 0; GLBPOL_FmRdy = 0;
        K = 0; N = 0; TOT = 0;
        do_reset("rst0");

        idx_list.delete();
        for (int i = 0; i < 6; i++)
            idx_list.push_back(100 + i);
        mem[100][7:0] = 8'd5; mem[101][7:0] = 8'd9; mem[102][7:0] = 8'd2;
        mem[103][7:0] = 8'd7; mem[104][7:0] = 8'd1; mem[105][7:0] = 8'd3;
        run_layer(3, 2, 1, 0, 0, 0);
        chk("t1_p0", got_q[0][7:0], 8'd9);
        chk("t1_p1", got_q[1][7:0], 8'd7);

        run_layer(1, 4, 0, 1, 1, 0);
        for (int p = 0; p < 4; p++)
            chk("t2_pass", got_q[p], mem[idx_list[p]]);

        run_layer(2, 3, 0, 1, 1, 30);

        idx_list.delete();
        idx_list.push_back(200);
        idx_list.push_back(201);
        mem[200][7:0] = 8'h80;
        mem[201][7:0] = 8'h7F;
`ifdef POL_SIGNED_EN
        lane_exp = 8'h7F;
`else
        lane_exp = 8'h80;
`endif
        run_layer(2, 1, 1, 0, 0, 0);
        chk("t5_lane0", got_q[0][7:0], lane_exp);

        for (int r = 0; r < 8; r++)
            run_layer(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)),
                      0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        run_layer(2, 0, 0, 0, 0, 0);

        src_full = 1; rdy_full = 1; sink_mode = 1; src_en = 1;
        ret_budget = 0;
        start_layer(4, 4, 0);
        repeat (25) cyc();
        chk("cap_issued", n_ih, 8);
        chk("cap_rdy", POLGLB_IdxRdy, 1'b0);
        ret_budget = 1;
        repeat (10) cyc();
        chk("cap_plus1", n_ih, 9);
        do_reset("rst_cap");

        src_full = 0; rdy_full = 0; sink_mode = 0; src_en = 1;
        ret_budget = -1;
        start_layer(3, 4, 0);
        for (int c = 0; c < 200 && n_ah < 3; c++)
            cyc();
        chk("t6_addr3", n_ah, 3);
        do_reset("rst_mid");
        MIFPOL_FmVld = 1'b1;
        #1;
        chk("idle_fmrdy", MIFPOL_FmRdy, 1'b0);
        MIFPOL_FmVld = 1'b0;
        run_layer(0, 5, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total_c, bad);
        $finish;
    end

endmodule
